// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: deframer state
// encoding, frame layout and the frame validity rule.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_CHECK = 3'b100
  } ps2_state_e;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_TIMEOUT_DEF = 20000;

  // Bits arrive LSB first and are shifted in from the top, so after the
  // last fall the start bit sits at bit 0 and the stop bit at bit 10.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  function automatic logic frame_ok(input ps2_frame_t f);
    return !f.start && f.stop && (^{f.data, f.parity});
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake of the PS/2 receiver: show-ahead head byte,
// ready/nextdata_n pop strobe and status flags.
interface ps2_rx_fifo_if;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  modport master (input nextdata_n, output data, ready, overflow, frame_err);
  modport slave  (output nextdata_n, input data, ready, overflow, frame_err);
endinterface

// File: rtl/byte_fifo.sv
// Show-ahead FIFO with wrap-bit pointers; a push into a full FIFO only
// lands when a pop frees the head slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Only entry 0 is cleared so the head reads a defined 8'h00 after reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem[0] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: line synchroniser, 11-bit frame deframer and
// show-ahead byte FIFO read through a ready / nextdata_n handshake.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = PS2_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.master rx
);
  localparam int         TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, fall, sdat;

  // Synchronisers idle high like the open-collector bus.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sdat = dat_sync[SYNC_STAGES-1];
  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];

  ps2_state_e    state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  ps2_frame_t    frame, frame_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          push, frame_err;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      frame   <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      frame   <= frame_n;
      to_cnt  <= to_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    frame_n   = frame;
    to_cnt_n  = '0;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE: begin
        // A high sample on a fall is not a start bit; keep hunting.
        if (fall && !sdat) begin
          frame_n   = ps2_frame_t'({sdat, frame[PS2_FRAME_BITS-1:1]});
          bit_cnt_n = 4'd1;
          state_n   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          frame_n   = ps2_frame_t'({sdat, frame[PS2_FRAME_BITS-1:1]});
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) state_n = ST_CHECK;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          state_n   = ST_IDLE;
          bit_cnt_n = '0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        state_n   = ST_IDLE;
        bit_cnt_n = '0;
        if (frame_ok(frame)) push = 1'b1;
        else                 frame_err = 1'b1;
      end
      default: begin
        state_n   = ST_IDLE;
        bit_cnt_n = '0;
      end
    endcase
  end

  logic       fifo_full, fifo_empty, pop, overflow;
  logic [7:0] head;

  assign pop = !rx.nextdata_n && !fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .din   (frame.data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A simultaneous pop makes room, so only an unmatched push into full drops.
  always_ff @(posedge clk) begin
    if (!clrn)                             overflow <= 1'b0;
    else if (push && fifo_full && !pop)    overflow <= 1'b1;
  end

  assign rx.data      = head;
  assign rx.ready     = !fifo_empty;
  assign rx.overflow  = overflow;
  assign rx.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: bit-banged PS/2 frames, a queue model of the FIFO
// checked every cycle, plus literal expectations on the directed scenarios.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TMO   = 200;
  localparam int HALF  = 8;
  // Edges from the stop-bit fall being driven to the push edge:
  // SYNC synchroniser flops, the CHECK cycle, then the push.
  localparam int LAT   = SYNC + 2;

  logic clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;

  ps2_rx_fifo_if rx();

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx)
  );

  always #5 clk = ~clk;

  typedef struct { int at; logic [7:0] b; bit ok; } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  ev_t        ev;
  bit         movf, chk_en, m_pop, exp_err, rnd_done, pop_done;
  int         cyc, nvec, nerr, pulses, last_edge, pop_rate, p0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        last_edge = cyc + LAT;
        evq.push_back('{cyc + LAT, b, !bad_par && !bad_stop});
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk); ps2_data = 1'b1;
  endtask

  task automatic pop_expect(input logic [7:0] b);
    @(negedge clk);
    chk("pop_ready", 32'(rx.ready), 32'd1);
    chk("pop_data", 32'(rx.data), 32'(b));
    rx.nextdata_n = 1'b0;
    @(negedge clk);
    rx.nextdata_n = 1'b1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); clrn = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_ready", 32'(rx.ready), 32'd0);
    chk("rst_data", 32'(rx.data), 32'h00);
    chk("rst_overflow", 32'(rx.overflow), 32'd0);
    chk("rst_frame_err", 32'(rx.frame_err), 32'd0);
    clrn = 1'b1;
  endtask

  initial begin
    rx.nextdata_n = 1'b1;
    fork
      // ---------------- stimulus ----------------
      begin
        do_reset(3);

        // Single 0x1C, then one pop empties the FIFO.
        send_frame(8'h1C, 0, 0, 11);
        chk("1c_ready", 32'(rx.ready), 32'd1);
        chk("1c_data", 32'(rx.data), 32'h1C);
        pop_expect(8'h1C);
        @(negedge clk) chk("1c_empty", 32'(rx.ready), 32'd0);

        // Three queued bytes come back in order.
        send_frame(8'h1C, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h1C, 0, 0, 11);
        pop_expect(8'h1C); pop_expect(8'hF0); pop_expect(8'h1C);
        @(negedge clk);
        chk("seq_empty", 32'(rx.ready), 32'd0);
        chk("seq_ovf", 32'(rx.overflow), 32'd0);

        // Bad parity: one frame_err cycle, nothing queued; next frame fine.
        p0 = pulses;
        send_frame(8'h1C, 1, 0, 11);
        chk("par_pulses", 32'(pulses - p0), 32'd1);
        chk("par_ready", 32'(rx.ready), 32'd0);
        send_frame(8'h32, 0, 0, 11);
        pop_expect(8'h32);

        // Nine frames into an 8-deep FIFO: 0x09 dropped, overflow sticky.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 11);
        chk("ovf_set", 32'(rx.overflow), 32'd1);
        for (int i = 1; i <= 8; i++) pop_expect(8'(i));
        @(negedge clk);
        chk("ovf_drained", 32'(rx.ready), 32'd0);
        chk("ovf_sticky", 32'(rx.overflow), 32'd1);

        // Full FIFO with a pop on the push edge: 0x09 accepted, no overflow.
        do_reset(2);
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0, 11);
        last_edge = 0;
        pop_done  = 0;
        fork
          send_frame(8'h09, 0, 0, 11);
          begin
            for (int k = 0; k < 3000 && !pop_done; k++) begin
              @(negedge clk);
              if (last_edge != 0 && cyc == last_edge - 1) begin
                rx.nextdata_n = 1'b0;
                @(negedge clk);
                rx.nextdata_n = 1'b1;
                pop_done = 1;
              end
            end
            if (!pop_done) begin
              nerr++;
              $display("FAIL pop_at_push: push edge not reached, last_edge %0d", last_edge);
            end
          end
        join
        chk("pp_ovf", 32'(rx.overflow), 32'd0);
        chk("pp_head", 32'(rx.data), 32'h02);
        for (int i = 2; i <= 9; i++) pop_expect(8'(i));
        @(negedge clk) chk("pp_empty", 32'(rx.ready), 32'd0);

        // Partial frame abandoned by timeout, then a clean 0xF0.
        p0 = pulses;
        send_frame(8'h55, 0, 0, 5);
        repeat (TMO + 60) @(negedge clk);
        send_frame(8'hF0, 0, 0, 11);
        chk("tmo_pulses", 32'(pulses - p0), 32'd0);
        pop_expect(8'hF0);
        @(negedge clk) chk("tmo_empty", 32'(rx.ready), 32'd0);

        // Reset mid-frame with a byte queued, then a fresh frame.
        send_frame(8'hA7, 0, 0, 11);
        send_frame(8'h3C, 0, 0, 6);
        do_reset(3);
        send_frame(8'h5A, 0, 0, 11);
        pop_expect(8'h5A);

        // Random traffic: slow consumer first (fills/overflows), then fast.
        rnd_done = 0;
        pop_rate = 1;
        fork
          begin
            for (int n = 0; n < 40; n++) begin
              if (n == 20) pop_rate = 300;
              send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                         $urandom_range(0, 7) == 0, 11);
              repeat ($urandom_range(0, 30)) @(negedge clk);
            end
            rnd_done = 1;
          end
          while (!rnd_done) begin
            @(negedge clk);
            rx.nextdata_n = !($urandom_range(0, 999) < pop_rate);
          end
        join
        rx.nextdata_n = 1'b0;
        repeat (DEPTH + 4) @(negedge clk);
        rx.nextdata_n = 1'b1;
        @(negedge clk) chk("rnd_drained", 32'(rx.ready), 32'd0);
      end

      // ---------------- model: update at each active edge ----------------
      forever begin
        @(posedge clk);
        cyc++;
        if (!clrn) begin
          mq.delete();
          evq.delete();
          movf   = 0;
          chk_en = 1;
        end else begin
          m_pop = !rx.nextdata_n && mq.size() != 0;
          if (m_pop) void'(mq.pop_front());
          if (evq.size() != 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            if (ev.ok) begin
              if (mq.size() < DEPTH) mq.push_back(ev.b);
              else                   movf = 1;
            end
          end
        end
      end

      // ---------------- compare: opposite edge ----------------
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("ready", 32'(rx.ready), 32'(mq.size() != 0));
          if (mq.size() != 0) chk("data", 32'(rx.data), 32'(mq[0]));
          chk("overflow", 32'(rx.overflow), 32'(movf));
          exp_err = evq.size() != 0 && evq[0].at == cyc + 1 && !evq[0].ok;
          chk("frame_err", 32'(rx.frame_err), 32'(exp_err));
          if (rx.frame_err === 1'b1) pulses++;
        end
      end

      // ---------------- watchdog ----------------
      begin
        repeat (95000) @(posedge clk);
        nerr++;
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
